// File: rtl/lock_reset_sequencer.sv
// Reset sequencer for the generated clock domain: synchronises LOCKED, releases reset after a
// stable-lock window, issues the SPI clock-enable tick and counts lock-loss events.
module lock_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int CE_DIV        = 6,
    parameter int LOSS_W        = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_locked,
    output logic              o_reset_n,
    output logic              o_ce,
    output logic              o_running,
    output logic [LOSS_W-1:0] o_loss_count
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("lock_reset_sequencer: SYNC_STAGES must be >= 2");
        end
        if (STABLE_CYCLES < 2) begin : g_bad_stable
            $error("lock_reset_sequencer: STABLE_CYCLES must be >= 2");
        end
        if (CE_DIV < 2) begin : g_bad_div
            $error("lock_reset_sequencer: CE_DIV must be >= 2");
        end
    endgenerate

    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam int DIV_W  = $clog2(CE_DIV);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ZERO = {STAB_W{1'b0}};
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CE_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [LOSS_W-1:0] LOSS_MAX  = {LOSS_W{1'b1}};
    localparam logic [LOSS_W-1:0] LOSS_ONE  = LOSS_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Saturating increment: the debug counter must never wrap back to a small value.
    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] value);
        logic [LOSS_W-1:0] result;
        if (value == LOSS_MAX) begin
            result = value;
        end else begin
            result = value + LOSS_ONE;
        end
        return result;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_s;
    state_t                 state_r;
    state_t                 state_s;
    logic [STAB_W-1:0]      stab_cnt_r;
    logic [STAB_W-1:0]      stab_cnt_s;
    logic [DIV_W-1:0]       div_cnt_r;
    logic [DIV_W-1:0]       div_cnt_s;
    logic [LOSS_W-1:0]      loss_cnt_r;
    logic [LOSS_W-1:0]      loss_cnt_s;
    logic                   ce_r;
    logic                   ce_s;
    logic                   run_s;
    logic                   reset_r;
    logic                   running_r;

    // LOCKED synchroniser into the generated clock domain.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_locked};
        end
    end

    assign locked_s = sync_r[SYNC_STAGES-1];

    // Next-state, counter and output decode; a lock drop always wins over completion.
    always_comb begin
        state_s    = state_r;
        stab_cnt_s = stab_cnt_r;
        div_cnt_s  = div_cnt_r;
        loss_cnt_s = loss_cnt_r;
        ce_s       = 1'b0;
        run_s      = 1'b0;
        case (state_r)
            WAIT_LOCK: begin
                stab_cnt_s = STAB_ZERO;
                div_cnt_s  = DIV_ZERO;
                if (locked_s) begin
                    state_s = STABILIZE;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            STABILIZE: begin
                div_cnt_s = DIV_ZERO;
                if (!locked_s) begin
                    state_s    = WAIT_LOCK;
                    stab_cnt_s = STAB_ZERO;
                end else if (stab_cnt_r == STAB_LAST) begin
                    state_s    = RUN;
                    stab_cnt_s = STAB_ZERO;
                end else begin
                    state_s    = STABILIZE;
                    stab_cnt_s = stab_cnt_r + STAB_ONE;
                end
            end
            RUN: begin
                stab_cnt_s = STAB_ZERO;
                if (!locked_s) begin
                    state_s    = WAIT_LOCK;
                    div_cnt_s  = DIV_ZERO;
                    loss_cnt_s = sat_inc(loss_cnt_r);
                end else begin
                    state_s = RUN;
                    ce_s    = (div_cnt_r == DIV_LAST);
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_s = DIV_ZERO;
                    end else begin
                        div_cnt_s = div_cnt_r + DIV_ONE;
                    end
                end
            end
            default: begin
                state_s    = WAIT_LOCK;
                stab_cnt_s = STAB_ZERO;
                div_cnt_s  = DIV_ZERO;
            end
        endcase
        run_s = (state_s == RUN);
    end

    // State, counters and registered outputs; outputs come straight from flops.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= WAIT_LOCK;
            stab_cnt_r <= STAB_ZERO;
            div_cnt_r  <= DIV_ZERO;
            loss_cnt_r <= {LOSS_W{1'b0}};
            ce_r       <= 1'b0;
            reset_r    <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            stab_cnt_r <= stab_cnt_s;
            div_cnt_r  <= div_cnt_s;
            loss_cnt_r <= loss_cnt_s;
            ce_r       <= ce_s;
            reset_r    <= run_s;
            running_r  <= run_s;
        end
    end

    assign o_reset_n    = reset_r;
    assign o_running    = running_r;
    assign o_ce         = ce_r;
    assign o_loss_count = loss_cnt_r;

endmodule

// File: tb/tb_lock_reset_sequencer.sv
// Scoreboard bench for lock_reset_sequencer: a streak-based lock model predicts reset, tick and
// loss events; a monitor matches what the DUT presents against the expected-event queue.
module tb_lock_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 16;
    localparam int CEDIV  = 6;
    localparam int LW     = 8;
    localparam int LOSS_SAT = 255;

    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_CE   = 2;

    typedef struct {
        int edge_no;
        int kind;
        int loss;
    } ev_t;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic          i_locked;
    logic          o_reset_n;
    logic          o_ce;
    logic          o_running;
    logic [LW-1:0] o_loss_count;

    int  edge_cnt = 0;
    int  checks   = 0;
    int  failures = 0;
    ev_t exp_q[$];
    int  ce_log[$];
    int  last_rise_edge = -1;
    int  last_fall_edge = -1;

    // Reference model: run holds exactly while synchronised lock has been high for
    // more than STABLE consecutive edges; ticks every CEDIV edges after entering run.
    int m_streak = 0;
    bit m_run    = 1'b0;
    int m_loss   = 0;

    lock_reset_sequencer #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .CE_DIV       (CEDIV),
        .LOSS_W       (LW)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (i_reset_n),
        .i_locked    (i_locked),
        .o_reset_n   (o_reset_n),
        .o_ce        (o_ce),
        .o_running   (o_running),
        .o_loss_count(o_loss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_cnt);
        end
    endtask

    task automatic push_ev(input int e, input int kind, input int loss);
        ev_t ev;
        ev.edge_no = e;
        ev.kind    = kind;
        ev.loss    = loss;
        exp_q.push_back(ev);
    endtask

    // The value driven now is sampled at the next edge and seen by the sequencer SYNC edges later.
    task automatic model_edge(input logic v);
        int e;
        bit new_run;
        e = edge_cnt + 1 + SYNC;
        if (v) m_streak++;
        else   m_streak = 0;
        new_run = (m_streak >= STABLE + 1);
        if (new_run && !m_run) begin
            push_ev(e, EV_RISE, m_loss);
        end else if (!new_run && m_run) begin
            if (m_loss < LOSS_SAT) m_loss++;
            push_ev(e, EV_FALL, m_loss);
        end else if (new_run && ((m_streak - STABLE - 1) % CEDIV) == 0) begin
            push_ev(e, EV_CE, m_loss);
        end
        m_run = new_run;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_streak = 0;
        m_run    = 1'b0;
        m_loss   = 0;
    endtask

    task automatic drive_cycle(input logic v);
        i_locked = v;
        model_edge(v);
        @(negedge clk);
    endtask

    task automatic handle_event(input int kind);
        ev_t ev;
        if (exp_q.size() == 0 || exp_q[0].edge_no > edge_cnt) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d at edge %0d, expected none", kind, edge_cnt);
        end else begin
            ev = exp_q.pop_front();
            check("event_kind", kind, ev.kind);
            check("event_loss", o_loss_count, ev.loss);
            check("event_running", o_running, (kind == EV_FALL) ? 0 : 1);
            if (kind == EV_RISE) last_rise_edge = edge_cnt;
            if (kind == EV_FALL) last_fall_edge = edge_cnt;
            if (kind == EV_CE) ce_log.push_back(edge_cnt);
        end
    endtask

    // Monitor: matches every observed reset edge or tick against the expected-event queue.
    initial begin
        logic prev_rst;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (!i_reset_n) begin
                prev_rst = o_reset_n;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_event: kind %0d expected at edge %0d, now %0d",
                             exp_q[0].kind, exp_q[0].edge_no, edge_cnt);
                    void'(exp_q.pop_front());
                end
                if (o_reset_n !== prev_rst) handle_event(o_reset_n ? EV_RISE : EV_FALL);
                if (o_ce === 1'b1) handle_event(EV_CE);
                prev_rst = o_reset_n;
            end
        end
    end

    initial begin
        int base;
        i_locked  = 1'b1;
        i_reset_n = 1'b1;
        #1 i_reset_n = 1'b0;

        // Test 1: held in reset with lock high and the clock running.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_hold_reset_n", o_reset_n, 0);
            check("rst_hold_ce", o_ce, 0);
            check("rst_hold_running", o_running, 0);
            check("rst_hold_loss", o_loss_count, 0);
        end

        // Test 2: release with lock high.
        i_reset_n = 1'b1;
        ce_log.delete();
        base = edge_cnt;
        for (int i = 0; i < 45; i++) drive_cycle(1'b1);
        check("t2_rise_edge", last_rise_edge - base, 19);
        check("t2_ce_count", ce_log.size(), 4);
        if (ce_log.size() >= 3) begin
            check("t2_ce0", ce_log[0] - base, 25);
            check("t2_ce1", ce_log[1] - base, 31);
            check("t2_ce2", ce_log[2] - base, 37);
        end

        // Test 4: lose lock in run, then regain it.
        base = edge_cnt;
        for (int i = 0; i < 5; i++) drive_cycle(1'b0);
        check("t4_fall_edge", last_fall_edge - base, 3);
        check("t4_loss", o_loss_count, 1);
        check("t4_reset_low", o_reset_n, 0);
        base = edge_cnt;
        for (int i = 0; i < 25; i++) drive_cycle(1'b1);
        check("t4_rerise_edge", last_rise_edge - base, 19);

        // Random lock/glitch pattern against the model.
        for (int s = 0; s < 30; s++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 45));
            lo = int'($urandom_range(1, 6));
            for (int i = 0; i < hi; i++) drive_cycle(1'b1);
            for (int i = 0; i < lo; i++) drive_cycle(1'b0);
        end

        // Test 5: enough run/loss cycles to saturate the loss counter.
        for (int s = 0; s < 260; s++) begin
            for (int i = 0; i < 40; i++) drive_cycle(1'b1);
            for (int i = 0; i < 3; i++) drive_cycle(1'b0);
        end
        check("t5_loss_saturated", o_loss_count, LOSS_SAT);
        check("t5_model_loss", o_loss_count, m_loss);

        // Test 6: asynchronous reset mid-run, between clock edges.
        for (int i = 0; i < 30; i++) drive_cycle(1'b1);
        check("t6_pre_running", o_running, 1);
        @(posedge clk);
        #2;
        i_reset_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_reset_n", o_reset_n, 0);
        check("t6_async_ce", o_ce, 0);
        check("t6_async_running", o_running, 0);
        check("t6_async_loss", o_loss_count, 0);
        repeat (3) @(negedge clk);
        i_reset_n = 1'b1;
        last_rise_edge = -1;

        // Test 3 after the reset: short lock, short drop, then steady lock.
        for (int i = 0; i < 10; i++) drive_cycle(1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0);
        base = edge_cnt;
        for (int i = 0; i < 30; i++) drive_cycle(1'b1);
        check("t3_rise_edge", last_rise_edge - base, 19);
        check("t3_loss", o_loss_count, 0);

        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
